// File: rtl/fetch_queue_filler.sv
// Fetch stage that feeds the instruction queue. It generates sequential PCs and
// issues imem requests within a credit limit, pairs in-order responses with their
// tagged PCs, pushes {epoch, pc, instr} to the queue, and discards in-flight
// work when a branch redirect arrives.
module fetch_queue_filler #(
    parameter int unsigned       AddrW          = 32,
    parameter int unsigned       InstrW         = 32,
    parameter int unsigned       QueueDepth     = 16,
    parameter int unsigned       MaxOutstanding = 4,
    parameter int unsigned       EpochW         = 3,
    parameter logic [AddrW-1:0]  ResetPc        = '0
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic                                 redirect_valid,
    input  logic [AddrW-1:0]                     redirect_pc,
    output logic                                 imem_req_valid,
    output logic [AddrW-1:0]                     imem_req_addr,
    input  logic                                 imem_req_ready,
    input  logic                                 imem_rsp_valid,
    input  logic [InstrW-1:0]                    imem_rsp_data,
    output logic                                 q_push,
    output logic [EpochW+AddrW+InstrW-1:0]       q_data,
    input  logic                                 q_full,
    input  logic                                 q_pop_accepted,
    output logic [EpochW-1:0]                    fetch_epoch,
    output logic [$clog2(MaxOutstanding+1)-1:0]  outstanding
);

    localparam int unsigned CntW   = $clog2(MaxOutstanding + 1);
    localparam int unsigned OccW   = $clog2(QueueDepth + 1);
    localparam int unsigned SumW   = OccW + CntW + 1;
    localparam int unsigned PtrW   = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned TagW   = EpochW + AddrW;
    localparam int unsigned QDataW = EpochW + AddrW + InstrW;
    localparam logic [AddrW-1:0] PcStep = AddrW'(InstrW / 8);

    // Architectural state
    logic [AddrW-1:0]  pc;
    logic [EpochW-1:0] epoch;
    logic [OccW-1:0]   occ;
    logic [CntW-1:0]   drop_cnt;
    logic [PtrW-1:0]   wr_ptr;
    logic [PtrW-1:0]   rd_ptr;
    logic [TagW-1:0]   tags [MaxOutstanding];
    logic              run;

    // Next-state values
    logic [AddrW-1:0]  pc_d;
    logic [EpochW-1:0] epoch_d;
    logic [OccW-1:0]   occ_d;
    logic [CntW-1:0]   outstanding_d;
    logic [CntW-1:0]   drop_cnt_d;
    logic [PtrW-1:0]   wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_d;
    logic              q_push_d;
    logic [QDataW-1:0] q_data_d;

    logic              fire;
    logic              keep;
    logic [EpochW-1:0] tag_epoch;
    logic [AddrW-1:0]  tag_pc;
    logic [SumW-1:0]   credit_sum;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // Credit view: queue occupancy, requests in flight and the push about to land
    assign credit_sum = SumW'(occ) + SumW'(outstanding) + SumW'(q_push);

    // Request is combinational so a redirect suppresses it in the same cycle
    assign imem_req_valid = run && !redirect_valid
                            && (outstanding < CntW'(MaxOutstanding))
                            && (credit_sum < SumW'(QueueDepth - 1));
    assign imem_req_addr  = pc;
    assign fetch_epoch    = epoch;

    // Next-state: PC/epoch, in-flight accounting, drop decision and queue push
    always_comb begin
        pc_d          = pc;
        epoch_d       = epoch;
        occ_d         = occ + OccW'(q_push) - OccW'(q_pop_accepted);
        outstanding_d = outstanding;
        drop_cnt_d    = drop_cnt;
        wr_ptr_d      = wr_ptr;
        rd_ptr_d      = rd_ptr;
        q_push_d      = 1'b0;
        q_data_d      = q_data;

        fire                = imem_req_valid && imem_req_ready;
        {tag_epoch, tag_pc} = tags[rd_ptr];
        keep                = imem_rsp_valid && !redirect_valid
                              && (drop_cnt == '0) && (tag_epoch == epoch);

        if (redirect_valid) begin
            pc_d    = redirect_pc;
            epoch_d = epoch + EpochW'(1);
        end else if (fire) begin
            pc_d = pc + PcStep;
        end

        if (fire) begin
            wr_ptr_d = ptr_inc(wr_ptr);
        end
        if (imem_rsp_valid) begin
            rd_ptr_d = ptr_inc(rd_ptr);
        end

        case ({fire, imem_rsp_valid})
            2'b10:   outstanding_d = outstanding + CntW'(1);
            2'b01:   outstanding_d = outstanding - CntW'(1);
            default: outstanding_d = outstanding;
        endcase

        // Everything still in flight after a redirect belongs to the old path
        if (redirect_valid) begin
            drop_cnt_d = outstanding_d;
        end else if (imem_rsp_valid && !keep && (drop_cnt != '0)) begin
            drop_cnt_d = drop_cnt - CntW'(1);
        end

        if (keep) begin
            q_push_d = 1'b1;
            q_data_d = {tag_epoch, tag_pc, imem_rsp_data};
        end
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc          <= ResetPc;
            epoch       <= '0;
            occ         <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            q_push      <= 1'b0;
            q_data      <= '0;
            run         <= 1'b0;
        end else begin
            pc          <= pc_d;
            epoch       <= epoch_d;
            occ         <= occ_d;
            outstanding <= outstanding_d;
            drop_cnt    <= drop_cnt_d;
            wr_ptr      <= wr_ptr_d;
            rd_ptr      <= rd_ptr_d;
            q_push      <= q_push_d;
            q_data      <= q_data_d;
            run         <= 1'b1;
        end
    end

    // Tag tracker storage: {epoch, pc} of each accepted request, in issue order
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < MaxOutstanding; i++) begin
                tags[i] <= '0;
            end
        end else if (fire) begin
            tags[wr_ptr] <= {epoch, pc};
        end
    end

    // Credit must prevent pushing into a full queue
    push_while_full_a: assert property (@(posedge clk) disable iff (!rstn)
        !(q_push && q_full));

    // imem must not answer more requests than were accepted
    rsp_without_req_a: assert property (@(posedge clk) disable iff (!rstn)
        !(imem_rsp_valid && (outstanding == '0)));

endmodule

// File: tb/tb_fetch_queue_filler.sv
// Randomized bench for fetch_queue_filler: an imem model with random latency, a
// queue occupancy model, and a request-level reference model that predicts which
// responses survive redirects. Expected queue pushes go into a scoreboard that a
// separate monitor checks against q_push/q_data.
module tb_fetch_queue_filler;

    localparam int unsigned AW    = 32;
    localparam int unsigned IW    = 32;
    localparam int unsigned EW    = 3;
    localparam int unsigned QW    = EW + AW + IW;
    localparam int          QCAP  = 15;
    localparam int          MAXO  = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          imem_req_valid;
    logic [AW-1:0] imem_req_addr;
    logic          imem_req_ready = 1'b0;
    logic          imem_rsp_valid = 1'b0;
    logic [IW-1:0] imem_rsp_data = '0;
    logic          q_push;
    logic [QW-1:0] q_data;
    logic          q_full = 1'b0;
    logic          q_pop_accepted = 1'b0;
    logic [EW-1:0] fetch_epoch;
    logic [2:0]    outstanding;

    fetch_queue_filler dut (
        .clk            (clk),
        .rstn           (rstn),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .q_push         (q_push),
        .q_data         (q_data),
        .q_full         (q_full),
        .q_pop_accepted (q_pop_accepted),
        .fetch_epoch    (fetch_epoch),
        .outstanding    (outstanding)
    );

    initial forever #5 clk = ~clk;

    // One accepted imem request as the reference model sees it
    typedef struct {
        logic [AW-1:0] addr;
        int            ep;     // redirect count when issued (unwrapped)
        logic [IW-1:0] data;
        int            due;    // earliest cycle the imem answers
    } req_t;

    req_t          infl[$];
    logic [QW-1:0] sb[$];

    int            tests = 0;
    int            fails = 0;
    int            push_seen = 0;

    logic [AW-1:0] pc_m;
    int            redir_cnt;
    int            qcount;
    bit            push_pend;
    int            cyc;
    int            fires;
    int            max_out;

    int            cfg_lat_min, cfg_lat_max, cfg_ready, cfg_pop, cfg_redir, cfg_max_fires;
    bit            force_redir;
    logic [AW-1:0] force_pc;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic set_cfg(input int lmin, input int lmax, input int rdy, input int pop,
                           input int redir, input int maxf);
        cfg_lat_min = lmin; cfg_lat_max = lmax; cfg_ready = rdy;
        cfg_pop = pop; cfg_redir = redir; cfg_max_fires = maxf;
    endtask

    // One clock cycle: drive inputs, check request-side outputs, advance the model
    task automatic step();
        bit            redir, rdy, rsp, pop, keep, expv, fire;
        logic [AW-1:0] rpc;
        req_t          r;
        @(negedge clk);
        redir = force_redir || ($urandom_range(99) < 32'(cfg_redir));
        rpc   = force_redir ? force_pc : ($urandom & 32'hFFFF_FFFC);
        rdy   = ((cfg_max_fires < 0) || (fires < cfg_max_fires)) && ($urandom_range(99) < 32'(cfg_ready));
        rsp   = (infl.size() > 0) && (infl[0].due <= cyc);
        pop   = (qcount > 0) && ($urandom_range(99) < 32'(cfg_pop));
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_req_ready = rdy;
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? infl[0].data : $urandom;
        q_full         = (qcount == QCAP);
        q_pop_accepted = pop;
        #1;
        expv = !redir && (infl.size() < MAXO) && ((qcount + infl.size() + int'(push_pend)) < QCAP);
        check("req_valid", 128'(imem_req_valid), 128'(expv));
        check("req_addr", 128'(imem_req_addr), 128'(pc_m));
        check("outstanding", 128'(outstanding), 128'(infl.size()));
        check("fetch_epoch", 128'(fetch_epoch), 128'(redir_cnt % 8));
        if (int'(outstanding) > max_out) max_out = int'(outstanding);

        keep = 1'b0;
        if (rsp) begin
            r = infl.pop_front();
            keep = !redir && (r.ep == redir_cnt);
            if (keep) sb.push_back({3'(r.ep), r.addr, r.data});
        end
        fire = expv && rdy;
        if (fire) begin
            r.addr = pc_m;
            r.ep   = redir_cnt;
            r.data = $urandom;
            r.due  = cyc + int'($urandom_range(32'(cfg_lat_max), 32'(cfg_lat_min)));
            infl.push_back(r);
            pc_m  = pc_m + 32'd4;
            fires++;
        end
        if (redir) begin
            pc_m = rpc;
            redir_cnt++;
        end
        qcount      = qcount + int'(push_pend) - int'(pop);
        push_pend   = keep;
        cyc++;
        force_redir = 1'b0;
    endtask

    // Reset mid-operation: imem and queue are reset together with the DUT
    task automatic do_reset();
        @(negedge clk);
        redirect_valid = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
        q_full = 1'b0; q_pop_accepted = 1'b0; redirect_pc = '0;
        #3;
        rstn = 1'b0;
        infl.delete(); sb.delete();
        pc_m = '0; redir_cnt = 0; qcount = 0; push_pend = 1'b0;
        fires = 0; max_out = 0; push_seen = 0;
        #1;
        check("rst_req_valid", 128'(imem_req_valid), 128'(0));
        check("rst_req_addr", 128'(imem_req_addr), 128'(0));
        check("rst_q_push", 128'(q_push), 128'(0));
        check("rst_q_data", 128'(q_data), 128'(0));
        check("rst_epoch", 128'(fetch_epoch), 128'(0));
        check("rst_outstanding", 128'(outstanding), 128'(0));
        repeat (2) @(negedge clk);
        #3 rstn = 1'b1;
    endtask

    // Monitor: every q_push must match the oldest expected entry; none may be missing
    initial begin
        logic          qp;
        logic [QW-1:0] qd;
        forever begin
            @(negedge clk);
            qp = q_push;
            qd = q_data;
            check("q_push", 128'(qp), 128'(sb.size() != 0));
            if (qp) push_seen++;
            if (sb.size() != 0) begin
                if (qp) check("q_data", 128'(qd), 128'(sb[0]));
                void'(sb.pop_front());
            end
            #2;
            if (qp) check("push_not_full", 128'(q_full), 128'(0));
        end
    end

    initial begin
        int  p0;
        bit  found;
        cyc = 0;
        force_redir = 1'b0;
        force_pc = '0;
        set_cfg(1, 1, 100, 0, 0, -1);
        do_reset();

        // Fill from reset with no pops: exactly 15 pushes, then requests stop
        repeat (40) step();
        check("t1_push_count", 128'(push_seen), 128'(15));

        // Pop every cycle: sustained one push per cycle
        set_cfg(1, 1, 100, 100, 0, -1);
        repeat (20) step();
        p0 = push_seen;
        repeat (20) step();
        check("t2_sustained", 128'(push_seen - p0), 128'(20));

        // Long latency: outstanding limited by MaxOutstanding
        do_reset();
        set_cfg(10, 10, 100, 0, 0, -1);
        repeat (40) step();
        check("t3_peak_outstanding", 128'(max_out), 128'(MAXO));

        // Redirect to 0x100 with three requests in flight
        do_reset();
        set_cfg(5, 5, 100, 50, 0, -1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (infl.size() == 3) begin
                force_redir = 1'b1;
                force_pc = 32'h100;
                found = 1'b1;
            end
            step();
        end
        check("t4_setup", 128'(found), 128'(1));
        repeat (30) step();

        // Redirect in the same cycle as a response and a ready imem
        do_reset();
        set_cfg(1, 1, 100, 50, 0, -1);
        repeat (5) step();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if ((infl.size() > 0) && (infl[0].due <= cyc)) begin
                force_redir = 1'b1;
                force_pc = 32'h2000;
                found = 1'b1;
            end
            step();
        end
        check("t5_setup", 128'(found), 128'(1));
        repeat (10) step();

        // Reset with two requests in flight and five entries queued
        do_reset();
        set_cfg(4, 4, 100, 0, 0, 8);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if ((qcount == 5) && (infl.size() == 2)) found = 1'b1;
            else step();
        end
        check("t6_setup", 128'(found), 128'(1));
        do_reset();
        set_cfg(1, 1, 100, 0, 0, -1);
        repeat (30) step();

        // Randomized traffic with redirects, backpressure and variable latency
        do_reset();
        for (int b = 0; b < 8; b++) begin
            set_cfg(1, 1 + int'($urandom_range(5)), 30 + int'($urandom_range(70)),
                    20 + int'($urandom_range(80)), int'($urandom_range(10)), -1);
            repeat (100) step();
        end

        // Drain without new requests
        set_cfg(1, 1, 0, 100, 0, -1);
        repeat (20) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
